// File: rtl/de2_toggle_debouncer.sv
// Debouncer and synchroniser for the DE2 toggle switches.
// Each switch bit is brought into the clk domain through two flops, then
// qualified against a shared millisecond-style prescaler: a bit only takes a
// new level after it has disagreed with its debounced value for STABLE_TICKS
// consecutive prescaler ticks. Every physical flip therefore reaches the
// downstream edge-capturing PIO as exactly one edge.

// Per-bit stability qualifier. One instance per switch; all instances share
// the prescaler tick from the top level.
module de2_debounce_bit #(
   parameter int STABLE_TICKS = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic sync_in,
   output logic deb,
   output logic changed
);

   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic [CW-1:0] cnt;

   // Any agreement with the current level restarts qualification; only a
   // run of disagreeing ticks reaching LAST commits the new level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         deb     <= 1'b0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (sync_in == deb) begin
            cnt <= '0;
         end else if (tick && (cnt == LAST)) begin
            deb     <= sync_in;
            cnt     <= '0;
            changed <= 1'b1;
         end else if (tick) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// Top level: synchroniser, shared prescaler and an array of bit qualifiers.
module de2_toggle_debouncer #(
   parameter int WIDTH        = 18,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_debounced,
   output logic [WIDTH-1:0] changed,
   output logic             tick
);

   // A 1-cycle prescaler still needs a 1-bit counter to keep the code uniform.
   localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_DIV - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [PCW-1:0]   pc;

   // Two-flop synchroniser; the switch pins are fully asynchronous.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   // Free-running prescaler; tick is registered so it lands one cycle after
   // pc reaches its last value, giving the first tick in cycle TICK_DIV.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc   <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (pc == PC_LAST);
         if (pc == PC_LAST) pc <= '0;
         else               pc <= pc + PCW'(1);
      end
   end

   // Bits are independent; any subset may commit in the same cycle.
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      de2_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick),
         .sync_in (s2[g]),
         .deb     (sw_debounced[g]),
         .changed (changed[g])
      );
   end

endmodule

// File: tb/tb_de2_toggle_debouncer.sv
// Bench for de2_toggle_debouncer: a main instance with TICK_DIV=4,
// STABLE_TICKS=3 and a degenerate instance with both parameters at 1.
module tb_de2_toggle_debouncer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [17:0] sw_raw, sw_raw_d;
   logic [17:0] deb, chg, deb_d, chg_d;
   logic        tick, tick_d;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   de2_toggle_debouncer #(.WIDTH(18), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
      .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
      .sw_debounced(deb), .changed(chg), .tick(tick));

   de2_toggle_debouncer #(.WIDTH(18), .TICK_DIV(1), .STABLE_TICKS(1)) dut_d (
      .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw_d),
      .sw_debounced(deb_d), .changed(chg_d), .tick(tick_d));

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // cycles since reset release, counted on the active edge
   int cyc = 0;
   logic [17:0] prev = '0, prev_d = '0;

   always @(posedge clk) begin
      if (!reset_n) cyc = 0;
      else          cyc = cyc + 1;
   end

   // every-cycle checks: tick cadence, changed pulses exactly where debounced moves
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_deb", 32'(deb), 0);
         chk("rst_chg", 32'(chg), 0);
         chk("rst_tick", 32'(tick), 0);
         chk("rst_deb_d", 32'(deb_d), 0);
         prev   = '0;
         prev_d = '0;
      end else begin
         chk("tick", 32'(tick), 32'(cyc > 0 && cyc % 4 == 0));
         chk("tick_d", 32'(tick_d), 32'(cyc > 0));
         chk("chg_vs_deb", 32'(chg), 32'(deb ^ prev));
         chk("chg_vs_deb_d", 32'(chg_d), 32'(deb_d ^ prev_d));
         prev   = deb;
         prev_d = deb_d;
      end
   end

   typedef struct {
      logic [17:0] raw;
      int          hold;
      logic [17:0] exp_deb;
      logic [17:0] exp_chg;
      int          exp_pulses;
      int          lat_min;
      int          lat_max;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int pulses, lat, ticks;
      logic [17:0] chg_or;

      // raw, hold, debounced after, OR of changed, pulses, latency window
      tbl[0] = '{18'h00000, 20, 18'h00000, 18'h00000, 0, 0, 0};   // quiet after reset
      tbl[1] = '{18'h00001, 20, 18'h00001, 18'h00001, 1, 11, 14}; // clean rise
      tbl[2] = '{18'h00021,  5, 18'h00001, 18'h00000, 0, 0, 0};   // bit 5 glitch
      tbl[3] = '{18'h00001, 30, 18'h00001, 18'h00000, 0, 0, 0};   // glitch stays rejected
      tbl[4] = '{18'h00000, 20, 18'h00000, 18'h00001, 1, 11, 14}; // clean fall
      tbl[5] = '{18'h3FFFF, 20, 18'h3FFFF, 18'h3FFFF, 1, 11, 14}; // all bits up
      tbl[6] = '{18'h00000, 20, 18'h00000, 18'h3FFFF, 1, 11, 14}; // all bits down

      reset_n  = 1'b1;
      sw_raw   = '0;
      sw_raw_d = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         sw_raw = tbl[v].raw;
         pulses = 0; chg_or = '0; lat = -1;
         for (int j = 1; j <= tbl[v].hold; j++) begin
            @(negedge clk);
            if (chg != '0) begin
               pulses++;
               chg_or |= chg;
               if (lat < 0) lat = j - 1;
            end
         end
         chk($sformatf("vec%0d_deb", v), 32'(deb), 32'(tbl[v].exp_deb));
         chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(tbl[v].exp_pulses));
         chk($sformatf("vec%0d_chg", v), 32'(chg_or), 32'(tbl[v].exp_chg));
         if (tbl[v].exp_pulses > 0)
            chk($sformatf("vec%0d_latency_in_window", v),
                32'(lat >= tbl[v].lat_min && lat <= tbl[v].lat_max), 1);
         @(posedge clk); #1;
      end

      // bounce burst on bit 17: 3-cycle excursions never qualify
      pulses = 0;
      for (int t = 0; t < 30; t++) begin
         if (t % 3 == 0) sw_raw[17] = ~sw_raw[17];
         @(negedge clk);
         if (chg != '0) pulses++;
         @(posedge clk); #1;
      end
      chk("burst_quiet", 32'(pulses), 0);
      sw_raw[17] = 1'b1;
      pulses = 0; chg_or = '0; lat = -1;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         if (chg != '0) begin pulses++; chg_or |= chg; end
         if (deb[17] && lat < 0) lat = j - 1;
      end
      chk("burst_pulses", 32'(pulses), 1);
      chk("burst_chg", 32'(chg_or), 32'(18'h20000));
      chk("burst_latency_in_window", 32'(lat >= 11 && lat <= 14), 1);
      @(posedge clk); #1;
      sw_raw = '0;
      repeat (20) @(posedge clk);
      #1 chk("burst_clear", 32'(deb), 0);

      // reset mid-qualification, asserted while tick is high
      sw_raw = 18'h00003;
      ticks = 0;
      for (int j = 0; j < 20 && ticks < 2; j++) begin
         @(negedge clk);
         if (tick) ticks++;
      end
      chk("two_ticks_seen", 32'(ticks), 2);
      chk("pre_reset_deb", 32'(deb), 0);
      #1 reset_n = 1'b0;
      #1 chk("async_tick_clear", 32'(tick), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      lat = -1; chg_or = '0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         chg_or |= chg;
         if (deb == 18'h00003 && lat < 0) lat = j - 1;
      end
      chk("post_reset_latency_in_window", 32'(lat >= 11 && lat <= 14), 1);
      chk("post_reset_chg", 32'(chg_or), 32'(18'h00003));
      // async clear of a committed level, no clock edge in between
      @(posedge clk); #1 reset_n = 1'b0;
      #1 chk("async_deb_clear", 32'(deb), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      sw_raw = '0;
      repeat (6) @(posedge clk);
      #1;

      // degenerate instance: step on bit 3 lands exactly 3 cycles later
      sw_raw_d = 18'h00008;
      lat = -1; pulses = 0; chg_or = '0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (chg_d != '0) begin pulses++; chg_or |= chg_d; end
         if (deb_d[3] && lat < 0) lat = j - 1;
      end
      chk("degen_latency", 32'(lat), 3);
      chk("degen_pulses", 32'(pulses), 1);
      chk("degen_chg", 32'(chg_or), 32'(18'h00008));
      chk("degen_deb", 32'(deb_d), 32'(18'h00008));

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
